// File: rtl/spi_px_master.sv
// SPI mode 0 pixel master: one PIXEL_BITS full-duplex frame per CS assertion,
// MSB first, SCK half-period of CLK_DIV clk_i cycles.
module spi_px_master #(
  parameter int unsigned PIXEL_BITS = 24,
  parameter int unsigned CLK_DIV    = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  px_valid_i,
  output logic                  px_ready_o,
  input  logic [PIXEL_BITS-1:0] px_data_i,
  output logic                  px_valid_o,
  output logic [PIXEL_BITS-1:0] px_data_o,
  output logic                  busy_o,
  output logic                  spi_sck_o,
  output logic                  spi_cs_o,
  output logic                  spi_sdo_o,
  input  logic                  spi_sdi_i
);

  localparam int unsigned BCW = $clog2(PIXEL_BITS + 1);
  localparam int unsigned DCW = $clog2(CLK_DIV + 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(PIXEL_BITS - 1);
  localparam logic [BCW-1:0] BIT_END   = BCW'(PIXEL_BITS);
  localparam logic [DCW-1:0] DIV_LAST  = DCW'(CLK_DIV - 1);
  localparam logic [DCW-1:0] DIV_SETUP = DCW'(CLK_DIV);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                state, state_n;
  logic [DCW-1:0]        div_cnt;
  logic [BCW-1:0]        bit_cnt;
  logic [PIXEL_BITS-2:0] tx_sr;
  logic [PIXEL_BITS-1:0] rx_sr;
  logic                  handshake, sck_rise, sck_fall, frame_done;

  assign px_ready_o = (state == IDLE) && !reset_i;
  assign busy_o     = (state != IDLE);
  assign handshake  = px_valid_i && px_ready_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  // SETUP runs CLK_DIV+1 cycles (div_cnt 0..CLK_DIV) so that px_valid_o
  // lands 1 + CLK_DIV + 2*CLK_DIV*PIXEL_BITS cycles after the handshake.
  always_comb begin
    state_n    = state;
    sck_rise   = 1'b0;
    sck_fall   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (handshake) state_n = SETUP;
      SETUP: if (div_cnt == DIV_SETUP) begin
        state_n  = SHIFT;
        sck_rise = 1'b1;
      end
      SHIFT: if (div_cnt == DIV_LAST) begin
        if (spi_sck_o) begin
          sck_fall = 1'b1;
        end else if (bit_cnt == BIT_END) begin
          frame_done = 1'b1;
          state_n    = HOLD;
        end else begin
          sck_rise = 1'b1;
        end
      end
      HOLD:  if (div_cnt == DIV_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      px_valid_o <= 1'b0;
      px_data_o  <= '0;
      spi_sck_o  <= 1'b0;
      spi_cs_o   <= 1'b1;
      spi_sdo_o  <= 1'b0;
    end else begin
      px_valid_o <= frame_done;
      if (state_n != state || sck_rise || sck_fall) div_cnt <= '0;
      else if (state != IDLE)                       div_cnt <= div_cnt + DCW'(1);
      if (handshake) begin
        tx_sr     <= px_data_i[PIXEL_BITS-2:0];
        spi_sdo_o <= px_data_i[PIXEL_BITS-1];
        spi_cs_o  <= 1'b0;
        bit_cnt   <= '0;
      end
      if (sck_rise) begin
        spi_sck_o <= 1'b1;
        rx_sr     <= {rx_sr[PIXEL_BITS-2:0], spi_sdi_i};
      end
      // The falling edge advances MOSI; once the last bit has gone out it idles low.
      if (sck_fall) begin
        spi_sck_o <= 1'b0;
        tx_sr     <= tx_sr << 1;
        spi_sdo_o <= (bit_cnt == BIT_LAST) ? 1'b0 : tx_sr[PIXEL_BITS-2];
        bit_cnt   <= bit_cnt + BCW'(1);
      end
      if (frame_done) begin
        spi_cs_o  <= 1'b1;
        px_data_o <= rx_sr;
      end
    end
  end

endmodule

// File: tb/tb_spi_px_master.sv
// Directed bench for spi_px_master: three instances (CLK_DIV 2, 3, 5) each
// with a mode-0 slave model and a passive protocol monitor.
module tb_spi_px_master;
  localparam int unsigned NI = 3;
  localparam int unsigned PB = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          px_valid [NI];
  logic [PB-1:0] px_din   [NI];
  logic          px_ready [NI];
  logic          px_vout  [NI];
  logic [PB-1:0] px_dout  [NI];
  logic          busy     [NI];
  logic          sck      [NI];
  logic          cs       [NI];
  logic          sdo      [NI];
  logic          sdi      [NI];

  logic [PB-1:0] slv_word   [NI];
  logic [PB-1:0] slv_sr     [NI] = '{default: '0};
  logic [PB-1:0] mosi_sr    [NI] = '{default: '0};
  logic [PB-1:0] mosi_last  [NI] = '{default: '0};
  int unsigned   rise_cnt   [NI] = '{default: 0};
  int unsigned   rises_last [NI] = '{default: 0};
  int unsigned   valid_cnt  [NI] = '{default: 0};
  int unsigned   frame_cnt  [NI] = '{default: 0};
  int unsigned   proto_err  [NI] = '{default: 0};
  int unsigned   gap_last   [NI] = '{default: 0};
  int unsigned   cs_hi      [NI] = '{default: 0};
  int unsigned   hi_cnt     [NI] = '{default: 0};
  int unsigned   lo_cnt     [NI] = '{default: 0};
  bit            hi_ok      [NI] = '{default: 1'b0};
  bit            lo_ok      [NI] = '{default: 1'b0};
  bit            p_cs       [NI] = '{default: 1'b1};
  bit            p_sck      [NI] = '{default: 1'b0};
  bit            p_v        [NI] = '{default: 1'b0};
  longint unsigned cyc = 0;
  longint unsigned valid_t      [NI] = '{default: 0};
  longint unsigned valid_t_prev [NI] = '{default: 0};

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      spi_px_master #(.PIXEL_BITS(PB), .CLK_DIV((g == 0) ? 2 : (g == 1) ? 3 : 5)) u_dut (
        .clk_i(clk), .reset_i(rst),
        .px_valid_i(px_valid[g]), .px_ready_o(px_ready[g]), .px_data_i(px_din[g]),
        .px_valid_o(px_vout[g]), .px_data_o(px_dout[g]), .busy_o(busy[g]),
        .spi_sck_o(sck[g]), .spi_cs_o(cs[g]), .spi_sdo_o(sdo[g]), .spi_sdi_i(sdi[g]));
      assign sdi[g] = slv_sr[g][PB-1];
    end
  endgenerate

  function automatic int unsigned cd_of(input int unsigned i);
    return (i == 0) ? 2 : (i == 1) ? 3 : 5;
  endfunction

  // Slave model (loads on CS fall, shifts on SCK fall) plus protocol monitor.
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int unsigned i = 0; i < NI; i++) begin
      if (rst) begin
        p_cs[i] = 1'b1; p_sck[i] = 1'b0; p_v[i] = 1'b0;
        hi_ok[i] = 1'b0; lo_ok[i] = 1'b0; cs_hi[i] = 0;
      end else begin
        if (cs[i] && sck[i]) proto_err[i]++;
        if ((cs[i] != p_cs[i]) && p_sck[i]) proto_err[i]++;
        if (!cs[i] && p_cs[i]) begin
          slv_sr[i] = slv_word[i]; rise_cnt[i] = 0; mosi_sr[i] = '0;
          gap_last[i] = cs_hi[i]; frame_cnt[i]++; lo_ok[i] = 1'b0;
        end
        if (cs[i] && !p_cs[i]) begin
          mosi_last[i] = mosi_sr[i]; rises_last[i] = rise_cnt[i];
          if (lo_ok[i] && lo_cnt[i] != cd_of(i)) proto_err[i]++;
          lo_ok[i] = 1'b0;
        end
        cs_hi[i] = cs[i] ? cs_hi[i] + 1 : 0;
        if (sck[i] && !p_sck[i]) begin
          if (lo_ok[i] && lo_cnt[i] != cd_of(i)) proto_err[i]++;
          hi_cnt[i] = 1; hi_ok[i] = 1'b1; rise_cnt[i]++;
          mosi_sr[i] = {mosi_sr[i][PB-2:0], sdo[i]};
        end else if (sck[i]) begin
          hi_cnt[i]++;
        end
        if (!sck[i] && p_sck[i]) begin
          if (hi_ok[i] && hi_cnt[i] != cd_of(i)) proto_err[i]++;
          lo_cnt[i] = 1; lo_ok[i] = 1'b1;
          slv_sr[i] = slv_sr[i] << 1;
        end else if (!sck[i]) begin
          lo_cnt[i]++;
        end
        if (px_vout[i] && p_v[i]) proto_err[i]++;
        if (px_vout[i] && !p_v[i]) begin
          valid_cnt[i]++; valid_t_prev[i] = valid_t[i]; valid_t[i] = cyc;
        end
        p_cs[i] = cs[i]; p_sck[i] = sck[i]; p_v[i] = px_vout[i];
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic start_frame(input int unsigned i, input logic [PB-1:0] d, input logic [PB-1:0] s);
    int unsigned n = 0;
    while (!px_ready[i] && n < 400) begin tick(); n++; end
    slv_word[i] = s; px_din[i] = d; px_valid[i] = 1'b1;
    @(posedge clk);
    tick();
    px_valid[i] = 1'b0; px_din[i] = ~d;
  endtask

  task automatic wait_valid(input int unsigned i, output int unsigned k);
    k = 0;
    for (int unsigned n = 1; n <= 400; n++) begin
      tick();
      if (px_vout[i]) begin k = n; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    nvec++; if (cs[0] !== 1'b1)       begin nerr++; $display("FAIL rst_cs: got %b want 1", cs[0]); end
    nvec++; if (sck[0] !== 1'b0)      begin nerr++; $display("FAIL rst_sck: got %b want 0", sck[0]); end
    nvec++; if (sdo[0] !== 1'b0)      begin nerr++; $display("FAIL rst_sdo: got %b want 0", sdo[0]); end
    nvec++; if (px_vout[0] !== 1'b0)  begin nerr++; $display("FAIL rst_valid: got %b want 0", px_vout[0]); end
    nvec++; if (px_dout[0] !== '0)    begin nerr++; $display("FAIL rst_data: got %h want 0", px_dout[0]); end
    nvec++; if (busy[0] !== 1'b0)     begin nerr++; $display("FAIL rst_busy: got %b want 0", busy[0]); end
    nvec++; if (px_ready[0] !== 1'b0) begin nerr++; $display("FAIL rst_ready: got %b want 0", px_ready[0]); end
    rst = 1'b0;
    #1;
    nvec++; if (px_ready[0] !== 1'b1) begin nerr++; $display("FAIL rst_release_ready: got %b want 1", px_ready[0]); end
  endtask

  task automatic test_single();
    int unsigned vk = 0, rk = 0, v0;
    v0 = valid_cnt[0];
    start_frame(0, 24'hA5C3F0, 24'h3C0F81);
    nvec++; if (busy[0] !== 1'b1)     begin nerr++; $display("FAIL single_busy: got %b want 1", busy[0]); end
    nvec++; if (px_ready[0] !== 1'b0) begin nerr++; $display("FAIL single_ready_low: got %b want 0", px_ready[0]); end
    for (int unsigned n = 1; n <= 200; n++) begin
      tick();
      if (vk == 0 && px_vout[0]) vk = n;
      else if (vk != 0 && px_ready[0]) begin rk = n; break; end
    end
    nvec++; if (vk !== 99)              begin nerr++; $display("FAIL single_valid_cycle: got %0d want 99", vk); end
    nvec++; if (rk !== 101)             begin nerr++; $display("FAIL single_ready_cycle: got %0d want 101", rk); end
    nvec++; if (px_dout[0] !== 24'h3C0F81)   begin nerr++; $display("FAIL single_rx: got %h want 3c0f81", px_dout[0]); end
    nvec++; if (mosi_last[0] !== 24'hA5C3F0) begin nerr++; $display("FAIL single_mosi: got %h want a5c3f0", mosi_last[0]); end
    nvec++; if (rises_last[0] !== PB)   begin nerr++; $display("FAIL single_sck_pulses: got %0d want 24", rises_last[0]); end
    nvec++; if (valid_cnt[0] - v0 !== 1) begin nerr++; $display("FAIL single_valid_count: got %0d want 1", valid_cnt[0] - v0); end
    nvec++; if (sdo[0] !== 1'b0)        begin nerr++; $display("FAIL single_sdo_idle: got %b want 0", sdo[0]); end
    nvec++; if (proto_err[0] !== 0)     begin nerr++; $display("FAIL single_protocol: got %0d violations want 0", proto_err[0]); end
  endtask

  task automatic test_busy_ignore();
    int unsigned v0, f0;
    v0 = valid_cnt[0]; f0 = frame_cnt[0];
    start_frame(0, 24'h9E3779, 24'h6B8B45);
    for (int unsigned n = 1; n <= 80; n++) begin
      tick();
      px_din[0] = 24'h123456;
      px_valid[0] = (n % 2 == 1);
    end
    px_valid[0] = 1'b0;
    repeat (60) tick();
    nvec++; if (mosi_last[0] !== 24'h9E3779) begin nerr++; $display("FAIL busy_mosi: got %h want 9e3779", mosi_last[0]); end
    nvec++; if (px_dout[0] !== 24'h6B8B45)   begin nerr++; $display("FAIL busy_rx: got %h want 6b8b45", px_dout[0]); end
    nvec++; if (frame_cnt[0] - f0 !== 1)     begin nerr++; $display("FAIL busy_frames: got %0d want 1", frame_cnt[0] - f0); end
    nvec++; if (valid_cnt[0] - v0 !== 1)     begin nerr++; $display("FAIL busy_valids: got %0d want 1", valid_cnt[0] - v0); end
    nvec++; if (px_ready[0] !== 1'b1)        begin nerr++; $display("FAIL busy_idle_ready: got %b want 1", px_ready[0]); end
  endtask

  task automatic test_back_to_back();
    int unsigned f0, n;
    f0 = frame_cnt[0];
    n = 0;
    while (!px_ready[0] && n < 400) begin tick(); n++; end
    slv_word[0] = 24'hA0A0A0; px_din[0] = 24'h000001; px_valid[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!px_vout[0] && n < 300);
    px_din[0] = 24'hFFFFFF; slv_word[0] = 24'h5F5F5F;
    nvec++; if (mosi_last[0] !== 24'h000001) begin nerr++; $display("FAIL b2b_mosi0: got %h want 000001", mosi_last[0]); end
    nvec++; if (px_dout[0] !== 24'hA0A0A0)   begin nerr++; $display("FAIL b2b_rx0: got %h want a0a0a0", px_dout[0]); end
    nvec++; if (rises_last[0] !== PB)        begin nerr++; $display("FAIL b2b_pulses0: got %0d want 24", rises_last[0]); end
    n = 0;
    do begin tick(); n++; end while (!px_vout[0] && n < 300);
    px_valid[0] = 1'b0;
    nvec++; if (valid_t[0] - valid_t_prev[0] !== 102) begin nerr++; $display("FAIL b2b_valid_spacing: got %0d want 102", valid_t[0] - valid_t_prev[0]); end
    nvec++; if (gap_last[0] !== 3)           begin nerr++; $display("FAIL b2b_cs_gap: got %0d want 3", gap_last[0]); end
    nvec++; if (rises_last[0] !== PB)        begin nerr++; $display("FAIL b2b_pulses1: got %0d want 24", rises_last[0]); end
    nvec++; if (mosi_last[0] !== 24'hFFFFFF) begin nerr++; $display("FAIL b2b_mosi1: got %h want ffffff", mosi_last[0]); end
    nvec++; if (px_dout[0] !== 24'h5F5F5F)   begin nerr++; $display("FAIL b2b_rx1: got %h want 5f5f5f", px_dout[0]); end
    repeat (10) tick();
    nvec++; if (frame_cnt[0] - f0 !== 2)     begin nerr++; $display("FAIL b2b_frames: got %0d want 2", frame_cnt[0] - f0); end
  endtask

  task automatic test_reset_mid();
    int unsigned v0, k, n;
    v0 = valid_cnt[0];
    start_frame(0, 24'hC0FFEE, 24'h123ABC);
    n = 0;
    while (rise_cnt[0] != 10 && n < 200) begin tick(); n++; end
    #2 rst = 1'b1;
    #1;
    nvec++; if (cs[0] !== 1'b1)      begin nerr++; $display("FAIL mid_rst_cs: got %b want 1", cs[0]); end
    nvec++; if (sck[0] !== 1'b0)     begin nerr++; $display("FAIL mid_rst_sck: got %b want 0", sck[0]); end
    nvec++; if (px_vout[0] !== 1'b0) begin nerr++; $display("FAIL mid_rst_valid: got %b want 0", px_vout[0]); end
    tick(); tick();
    rst = 1'b0;
    #1;
    nvec++; if (px_ready[0] !== 1'b1) begin nerr++; $display("FAIL mid_release_ready: got %b want 1", px_ready[0]); end
    repeat (120) tick();
    nvec++; if (valid_cnt[0] - v0 !== 0) begin nerr++; $display("FAIL mid_no_valid: got %0d want 0", valid_cnt[0] - v0); end
    nvec++; if (px_dout[0] !== '0)       begin nerr++; $display("FAIL mid_data_cleared: got %h want 0", px_dout[0]); end
    start_frame(0, 24'h0F0F0F, 24'hE1D2C3);
    wait_valid(0, k);
    nvec++; if (k !== 99)                    begin nerr++; $display("FAIL mid_next_cycle: got %0d want 99", k); end
    nvec++; if (mosi_last[0] !== 24'h0F0F0F) begin nerr++; $display("FAIL mid_next_mosi: got %h want 0f0f0f", mosi_last[0]); end
    nvec++; if (px_dout[0] !== 24'hE1D2C3)   begin nerr++; $display("FAIL mid_next_rx: got %h want e1d2c3", px_dout[0]); end
  endtask

  task automatic test_protocol();
    logic [PB-1:0] d, s;
    int unsigned k, cd;
    for (int unsigned i = 0; i < NI; i++) begin
      cd = cd_of(i);
      for (int unsigned f = 0; f < 3; f++) begin
        d = PB'($urandom); s = PB'($urandom);
        start_frame(i, d, s);
        wait_valid(i, k);
        nvec++; if (k !== 1 + cd + 2 * cd * PB) begin nerr++; $display("FAIL proto_cycle div%0d: got %0d want %0d", cd, k, 1 + cd + 2 * cd * PB); end
        nvec++; if (px_dout[i] !== s)   begin nerr++; $display("FAIL proto_rx div%0d: got %h want %h", cd, px_dout[i], s); end
        nvec++; if (mosi_last[i] !== d) begin nerr++; $display("FAIL proto_mosi div%0d: got %h want %h", cd, mosi_last[i], d); end
        nvec++; if (rises_last[i] !== PB) begin nerr++; $display("FAIL proto_pulses div%0d: got %0d want 24", cd, rises_last[i]); end
      end
      nvec++; if (proto_err[i] !== 0) begin nerr++; $display("FAIL proto_timing div%0d: got %0d violations want 0", cd, proto_err[i]); end
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < NI; i++) begin
      px_valid[i] = 1'b0; px_din[i] = '0; slv_word[i] = '0;
    end
    test_reset();
    test_single();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
